// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP controller-sequencer: opcodes, T-state encodings, control word.
// No logic here; constants and types only.
// Control word fields keep the polarity seen on the pins (n_* are active low).
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // One-hot ring states, bit0 = T1
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_en;
    logic n_load_mar;
    logic n_ce;
    logic n_load_ir;
    logic n_enable_ir;
    logic n_load_a;
    logic a_en;
    logic alu_sub;
    logic alu_en;
    logic n_load_b;
    logic n_load_out;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_inc:      1'b0,
    pc_en:       1'b0,
    n_load_mar:  1'b1,
    n_ce:        1'b1,
    n_load_ir:   1'b1,
    n_enable_ir: 1'b1,
    n_load_a:    1'b1,
    a_en:        1'b0,
    alu_sub:     1'b0,
    alu_en:      1'b0,
    n_load_b:    1'b1,
    n_load_out:  1'b1
  };

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot six-state T-state ring, T1 -> T6 -> T1 with no idle cycle.
// Latency: state changes one clk after advance is seen.
// hold overrides advance; reset (sync, active low) overrides both.
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       hold,
  output logic [5:0] t_state
);

  t_state_e state;
  t_state_e state_nxt;

  // State register with synchronous reset to T1
  always_ff @(posedge clk) begin
    if (!rst_n) state <= T1;
    else        state <= state_nxt;
  end

  // Rotate one position when advancing and not held
  always_comb begin
    state_nxt = state;
    if (advance && !hold) begin
      case (state)
        T1:      state_nxt = T2;
        T2:      state_nxt = T3;
        T3:      state_nxt = T4;
        T4:      state_nxt = T5;
        T5:      state_nxt = T6;
        T6:      state_nxt = T1;
        default: state_nxt = T1;
      endcase
    end
  end

  assign t_state = state;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: fetch in T1-T3, decode opcode in T4-T6, HLT freezes at T4.
// Latency: control word is combinational from t_state/opcode/halted (zero cycles).
// Optional SAP_SINGLE_STEP_EN adds a step port; the ring then advances only on step rising edges.
module sap_controller_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int RING_LEN = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
`ifdef SAP_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                pc_inc,
  output logic                pc_en,
  output logic                n_load_mar,
  output logic                n_ce,
  output logic                n_load_ir,
  output logic                n_enable_ir,
  output logic                n_load_a,
  output logic                a_en,
  output logic                alu_sub,
  output logic                alu_en,
  output logic                n_load_b,
  output logic                n_load_out,
  output logic [RING_LEN-1:0] t_state,
  output logic                halted
);

  logic  advance;
  logic  halt_now;
  ctrl_t ctrl;

`ifdef SAP_SINGLE_STEP_EN
  logic step_q;

  // Registered copy of step for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign advance = step & ~step_q;
`else
  assign advance = 1'b1;
`endif

  // HLT is acted on at the T4 edge; the ring must not leave T4 on that same edge
  assign halt_now = (t_state == T4) && (opcode == OP_HLT);

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .hold    (halted | halt_now),
    .t_state (t_state)
  );

  // Halt flag: set at T4 of HLT, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)        halted <= 1'b0;
    else if (halt_now) halted <= 1'b1;
  end

  // Control word decode; idle during reset and once halted
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst_n && !halted) begin
      case (t_state)
        T1: begin
          ctrl.pc_en      = 1'b1;
          ctrl.n_load_mar = 1'b0;
        end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin
          ctrl.n_ce      = 1'b0;
          ctrl.n_load_ir = 1'b0;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.n_enable_ir = 1'b0;
              ctrl.n_load_mar  = 1'b0;
            end
            OP_OUT: begin
              ctrl.a_en       = 1'b1;
              ctrl.n_load_out = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ctrl.n_ce     = 1'b0;
              ctrl.n_load_a = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ctrl.n_ce     = 1'b0;
              ctrl.n_load_b = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_en   = 1'b1;
            ctrl.n_load_a = 1'b0;
            ctrl.alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign pc_inc      = ctrl.pc_inc;
  assign pc_en       = ctrl.pc_en;
  assign n_load_mar  = ctrl.n_load_mar;
  assign n_ce        = ctrl.n_ce;
  assign n_load_ir   = ctrl.n_load_ir;
  assign n_enable_ir = ctrl.n_enable_ir;
  assign n_load_a    = ctrl.n_load_a;
  assign a_en        = ctrl.a_en;
  assign alu_sub     = ctrl.alu_sub;
  assign alu_en      = ctrl.alu_en;
  assign n_load_b    = ctrl.n_load_b;
  assign n_load_out  = ctrl.n_load_out;

  // Only one source may drive the shared bus in any state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($countones({pc_en, ~n_ce, ~n_enable_ir, a_en, alu_en}) <= 1);
    end
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: directed per-cycle vectors feed a scoreboard queue,
// a negedge monitor pops and compares t_state, halted and the normalised control word.
// Signals are compared as an "active" mask (n_* inverted) so expectations read as asserted strobes.
module tb_sap_controller_sequencer;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  // Active mask bit positions: {pc_inc, pc_en, load_mar, ce, load_ir, enable_ir,
  //                             load_a, a_en, alu_sub, alu_en, load_b, load_out}
  localparam logic [11:0] PC_INC = 12'b1000_0000_0000;
  localparam logic [11:0] PC_EN  = 12'b0100_0000_0000;
  localparam logic [11:0] L_MAR  = 12'b0010_0000_0000;
  localparam logic [11:0] CE     = 12'b0001_0000_0000;
  localparam logic [11:0] L_IR   = 12'b0000_1000_0000;
  localparam logic [11:0] E_IR   = 12'b0000_0100_0000;
  localparam logic [11:0] L_A    = 12'b0000_0010_0000;
  localparam logic [11:0] A_EN   = 12'b0000_0001_0000;
  localparam logic [11:0] SUB    = 12'b0000_0000_1000;
  localparam logic [11:0] ALU    = 12'b0000_0000_0100;
  localparam logic [11:0] L_B    = 12'b0000_0000_0010;
  localparam logic [11:0] L_OUT  = 12'b0000_0000_0001;
  localparam logic [11:0] NONE   = 12'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       step = 1'b0;
  logic       pc_inc, pc_en, n_load_mar, n_ce, n_load_ir, n_enable_ir;
  logic       n_load_a, a_en, alu_sub, alu_en, n_load_b, n_load_out;
  logic [5:0] t_state;
  logic       halted;

  typedef struct {
    string      nm;
    logic [5:0] t;
    logic       h;
    logic [11:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sap_controller_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
`ifdef SAP_SINGLE_STEP_EN
    .step        (step),
`endif
    .pc_inc      (pc_inc),
    .pc_en       (pc_en),
    .n_load_mar  (n_load_mar),
    .n_ce        (n_ce),
    .n_load_ir   (n_load_ir),
    .n_enable_ir (n_enable_ir),
    .n_load_a    (n_load_a),
    .a_en        (a_en),
    .alu_sub     (alu_sub),
    .alu_en      (alu_en),
    .n_load_b    (n_load_b),
    .n_load_out  (n_load_out),
    .t_state     (t_state),
    .halted      (halted)
  );

  wire [11:0] act_obs = {pc_inc, pc_en, ~n_load_mar, ~n_ce, ~n_load_ir, ~n_enable_ir,
                         ~n_load_a, a_en, alu_sub, alu_en, ~n_load_b, ~n_load_out};

  // Monitor: one observation per cycle, away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (t_state !== e.t || halted !== e.h || act_obs !== e.act) begin
        n_bad++;
        $display("FAIL %s: got t_state=%b halted=%b active=%b, want t_state=%b halted=%b active=%b",
                 e.nm, t_state, halted, act_obs, e.t, e.h, e.act);
      end
    end
  end

  // Drive inputs just after the edge and queue what the following negedge must show
  task automatic cyc(input string nm, input logic [3:0] op, input logic r, input logic s,
                     input logic [5:0] t, input logic [11:0] a, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op;
    rst_n  = r;
    step   = s;
    e.nm = nm; e.t = t; e.h = h; e.act = a;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input string nm, input logic [3:0] op);
    cyc({nm, "_T1"}, op, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    cyc({nm, "_T2"}, op, 1'b1, 1'b0, S2, PC_INC,        1'b0);
    cyc({nm, "_T3"}, op, 1'b1, 1'b0, S3, CE | L_IR,     1'b0);
  endtask

  task automatic exec(input string nm, input logic [3:0] op,
                      input logic [11:0] a4, input logic [11:0] a5, input logic [11:0] a6);
    cyc({nm, "_T4"}, op, 1'b1, 1'b0, S4, a4, 1'b0);
    cyc({nm, "_T5"}, op, 1'b1, 1'b0, S5, a5, 1'b0);
    cyc({nm, "_T6"}, op, 1'b1, 1'b0, S6, a6, 1'b0);
  endtask

  initial begin
    cyc("rst_a", 4'h0, 1'b0, 1'b0, S1, NONE, 1'b0);
    cyc("rst_b", 4'h0, 1'b0, 1'b0, S1, NONE, 1'b0);
`ifdef SAP_SINGLE_STEP_EN
    cyc("ss_release", 4'h0, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("ss_hold_low", 4'h0, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    cyc("ss_rise1",  4'h0, 1'b1, 1'b1, S1, PC_EN | L_MAR, 1'b0);
    cyc("ss_adv1",   4'h0, 1'b1, 1'b0, S2, PC_INC,        1'b0);
    cyc("ss_rise2",  4'h0, 1'b1, 1'b1, S2, PC_INC,        1'b0);
    cyc("ss_adv2",   4'h0, 1'b1, 1'b0, S3, CE | L_IR,     1'b0);
    cyc("ss_rise3",  4'h0, 1'b1, 1'b1, S3, CE | L_IR,     1'b0);
    cyc("ss_adv3",   4'h0, 1'b1, 1'b1, S4, E_IR | L_MAR,  1'b0);
    for (int i = 0; i < 4; i++)
      cyc("ss_hold_high", 4'h0, 1'b1, 1'b1, S4, E_IR | L_MAR, 1'b0);
`else
    // Release reset: first observed state is T1 (edge still saw reset)
    cyc("release_T1", 4'h0, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    cyc("fetch0_T2",  4'h0, 1'b1, 1'b0, S2, PC_INC,        1'b0);
    cyc("fetch0_T3",  4'h0, 1'b1, 1'b0, S3, CE | L_IR,     1'b0);
    exec("lda", 4'h0, E_IR | L_MAR, CE | L_A, NONE);

    // HLT opcode during fetch must not halt or alter fetch strobes
    fetch("add_fetch", 4'hF);
    exec("add", 4'h1, E_IR | L_MAR, CE | L_B, ALU | L_A);
    fetch("sub_fetch", 4'h2);
    exec("sub", 4'h2, E_IR | L_MAR, CE | L_B, ALU | L_A | SUB);
    fetch("out_fetch", 4'hE);
    exec("out", 4'hE, A_EN | L_OUT, NONE, NONE);
    fetch("nop_fetch", 4'h5);
    exec("nop", 4'h5, NONE, NONE, NONE);

    // Reset during T5 of ADD: outputs idle at once, T1 on the next edge
    fetch("addrst_fetch", 4'h1);
    cyc("addrst_T4",   4'h1, 1'b1, 1'b0, S4, E_IR | L_MAR,  1'b0);
    cyc("addrst_T5",   4'h1, 1'b0, 1'b0, S5, NONE,          1'b0);
    cyc("addrst_T1",   4'h5, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    cyc("addrst_T2",   4'h5, 1'b1, 1'b0, S2, PC_INC,        1'b0);
    cyc("addrst_T3",   4'h5, 1'b1, 1'b0, S3, CE | L_IR,     1'b0);
    exec("nop2", 4'h5, NONE, NONE, NONE);

    // HLT freezes at T4 until reset, even if the opcode changes afterwards
    fetch("hlt_fetch", 4'hF);
    cyc("hlt_T4", 4'hF, 1'b1, 1'b0, S4, NONE, 1'b0);
    for (int i = 0; i < 11; i++)
      cyc("halted_hold", 4'h0, 1'b1, 1'b0, S4, NONE, 1'b1);
    cyc("halted_rst",   4'h0, 1'b0, 1'b0, S4, NONE,          1'b1);
    cyc("post_halt_T1", 4'h0, 1'b1, 1'b0, S1, PC_EN | L_MAR, 1'b0);
    cyc("post_halt_T2", 4'h0, 1'b1, 1'b0, S2, PC_INC,        1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
